// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with register-file write-back strobe
// One operation in flight: shift-add multiply, restoring divide, one bit per cycle.
module muldiv_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               funct3,
  input  logic [DATA_WIDTH-1:0]    op_a,
  input  logic [DATA_WIDTH-1:0]    op_b,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    result,
  output logic                     wb_en,
  output logic [ADDRESS_WIDTH-1:0] wb_addr
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t        state;
  logic [2:0]    op;
  logic [W-1:0]  a_q, b_q;
  logic [W-1:0]  hi, lo;
  logic [CW-1:0] cnt;
  logic          neg_res, neg_rem;

  logic          signed_a, signed_b, sign_a, sign_b;
  logic [W-1:0]  mag_a, mag_b;
  logic          div_zero, div_ovf;
  logic [W-1:0]  special_res;
  logic [W:0]    mul_sum, div_shift, div_diff;
  logic [2*W-1:0] prod, prod_s;
  logic [W-1:0]  quot_s, rem_s, fix_res;

  always_comb begin
    signed_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    signed_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    sign_a   = signed_a && a_q[W-1];
    sign_b   = signed_b && b_q[W-1];
    mag_a    = sign_a ? (~a_q + W'(1)) : a_q;
    mag_b    = sign_b ? (~b_q + W'(1)) : b_q;
    div_zero = (b_q == '0);
    // Only signed division can overflow: most-negative / -1.
    div_ovf  = !op[0] && (a_q == {1'b1, {(W-1){1'b0}}}) && (&b_q);
    if (div_zero) special_res = op[1] ? a_q : '1;
    else          special_res = op[1] ? '0 : a_q;
  end

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    div_shift = {hi, lo[W-1]};
    div_diff  = div_shift - {1'b0, b_q};
    prod      = {hi, lo};
    prod_s    = neg_res ? (~prod + (2*W)'(1)) : prod;
    quot_s    = neg_res ? (~lo + W'(1)) : lo;
    rem_s     = neg_rem ? (~hi + W'(1)) : hi;
    if (!op[2]) fix_res = (op[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W];
    else        fix_res = op[1] ? rem_s : quot_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      wb_en   <= 1'b0;
      result  <= '0;
      wb_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op      <= funct3;
            a_q     <= op_a;
            b_q     <= op_b;
            wb_addr <= rd_addr;
            busy    <= 1'b1;
            state   <= PREP;
          end
        end
        PREP: begin
          neg_res <= sign_a ^ sign_b;
          neg_rem <= sign_a;
          b_q     <= mag_b;
          hi      <= '0;
          lo      <= mag_a;
          cnt     <= '0;
          if (op[2] && (div_zero || div_ovf)) begin
            result <= special_res;
            done   <= 1'b1;
            wb_en  <= (wb_addr != '0);
            state  <= DONE;
          end else begin
            state  <= RUN;
          end
        end
        RUN: begin
          if (!op[2]) begin
            hi <= mul_sum[W:1];
            lo <= {mul_sum[0], lo[W-1:1]};
          end else if (!div_diff[W]) begin
            hi <= div_diff[W-1:0];
            lo <= {lo[W-2:0], 1'b1};
          end else begin
            hi <= div_shift[W-1:0];
            lo <= {lo[W-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W-1)) state <= FIX;
        end
        FIX: begin
          result <= fix_res;
          done   <= 1'b1;
          wb_en  <= (wb_addr != '0);
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          wb_en <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
